rptr_level_ctrl: RTL and testbench
==================================

Name: rptr_level_ctrl

Overview:
Read-side pointer and flag controller for the async FIFO, parametrised in depth and almost-empty threshold.
- Generates binary and Gray read pointers and a registered empty flag.
- Adds a fill-level count, an almost-empty flag, a read-acknowledge pulse and underflow detection.
- Sits in the read clock domain: consumes the 2-FF-synchronised Gray write pointer, drives the FIFO memory read address and the Gray pointer sent to the write-side synchroniser.

Parameters:
- PTR_WIDTH, 3, address width; FIFO depth = 2^PTR_WIDTH; pointers are PTR_WIDTH+1 bits (extra wrap bit).
- AEMPTY_THRESH, 1, almost_empty asserts when level <= AEMPTY_THRESH; legal range 0 .. 2^PTR_WIDTH-1.

Ports:
- rclk  in  1  read-domain clock.
- rrst  in  1  synchronous active-high reset, sampled on rising rclk.
- r_en  in  1  read request.
- g_wptr_sync  in  PTR_WIDTH+1  Gray write pointer, already synchronised into rclk.
- b_rptr  out  PTR_WIDTH+1  binary read pointer; low PTR_WIDTH bits are the memory read address.
- g_rptr  out  PTR_WIDTH+1  Gray read pointer, to the write-side synchroniser.
- empty  out  1  FIFO empty.
- almost_empty  out  1  level <= AEMPTY_THRESH.
- rd_level  out  PTR_WIDTH+1  entries available, range 0 .. 2^PTR_WIDTH.
- rd_ack  out  1  one-cycle pulse, the cycle after an accepted read.
- underflow  out  1  read attempted while empty.

Behaviour:
- All outputs registered on rising rclk. rrst has priority over every other input.
- Reset values: b_rptr=0, g_rptr=0, empty=1, almost_empty=1, rd_level=0, rd_ack=0, underflow=0.
- Read acceptance: rd_accept = r_en & !empty (uses the registered empty). Reads while empty leave the pointers unchanged.
- Next pointer, binary: b_next = b_rptr + rd_accept, modulo 2^(PTR_WIDTH+1); wraps 2^(PTR_WIDTH+1)-1 -> 0.
- Next pointer, Gray: g_next = b_next ^ (b_next >> 1).
- Write-pointer decode: b_wsync = Gray-to-binary of g_wptr_sync, combinational. MSB equals the Gray MSB; each lower bit = Gray bit XOR the next-higher decoded bit.
- Level: level_next = (b_wsync - b_next) mod 2^(PTR_WIDTH+1). No clamping; the value is only valid if g_wptr_sync is a legal synchronised pointer.
- Registered updates each cycle:
  - b_rptr <= b_next; g_rptr <= g_next.
  - empty <= (g_next == g_wptr_sync).
  - rd_level <= level_next.
  - almost_empty <= (level_next <= AEMPTY_THRESH).
- Timing: empty, rd_level and almost_empty reflect the pointer value that b_rptr/g_rptr hold in the same cycle.
- Back-to-back reads: r_en held high drains the FIFO at one entry per cycle. empty rises in the same cycle b_rptr reaches the write pointer; no over-read.
- Full FIFO (level 2^PTR_WIDTH): pointers differ only in MSB. empty=0 and rd_level = 2^PTR_WIDTH.
- Write arrives during the last read: a new g_wptr_sync and an accepted read in the same cycle are both reflected in the next registered flags.
- rd_ack <= rd_accept, so memory data addressed by the previous b_rptr is valid when rd_ack=1.
- underflow (default build) <= r_en & empty; a one-cycle pulse per offending cycle.
- Reset mid-stream: the pointers return to 0 regardless of g_wptr_sync. The write side must be reset in the same window; no recovery logic is provided.

Optional Feature:
- Macro: RPTR_UNDERFLOW_STICKY_EN.
- Defined:
  - Adds input port underflow_clr (1 bit).
  - underflow becomes sticky: it sets on r_en & empty and holds until a cycle with underflow_clr=1.
  - Simultaneous set and clear: set wins.
  - Reset clears it.
- Undefined: no underflow_clr port; underflow is the one-cycle pulse described above.

Test Plan:
1. Reset with PTR_WIDTH=3, AEMPTY_THRESH=1, g_wptr_sync=0 -> all outputs at reset values; r_en=1 for 3 cycles -> underflow pulses each cycle, b_rptr stays 0, rd_ack=0.
2. g_wptr_sync=4'b0010 (binary 3) with r_en=0 -> next cycle empty=0, rd_level=3, almost_empty=0. Then r_en=1 for 3 cycles, giving:
   - after read 1: b_rptr=1, rd_level=2, almost_empty=0;
   - after read 2: b_rptr=2, rd_level=1, almost_empty=1;
   - after read 3: b_rptr=3, g_rptr=4'b0010, empty=1, rd_level=0;
   - rd_ack high for exactly 3 cycles.
3. Full FIFO: g_wptr_sync=4'b1100 (binary 8) from reset -> rd_level=8, empty=0. Eight continuous reads -> b_rptr=4'b1000, g_rptr=4'b1100, empty=1; a ninth r_en is ignored and flags underflow.
4. Wrap-around: write pointer advancing one entry per cycle from 14 through 15 to 0 (Gray 1001 -> 1000 -> 0000) while reading continuously -> b_rptr wraps 15 -> 0; rd_level stays correct (computed mod 16); empty is never asserted falsely.
5. Mid-stream rrst=1 with rd_level=5 -> next edge: b_rptr=0, empty=1, rd_level=0, underflow=0, independent of r_en.
6. RPTR_UNDERFLOW_STICKY_EN defined:
   - r_en while empty -> underflow=1 and holds for 10 cycles;
   - underflow_clr=1 together with r_en on an empty FIFO -> underflow stays 1;
   - underflow_clr=1 alone -> underflow=0 next cycle.

Source files
------------

// File: rtl/rptr_level_ctrl_if.sv
// Read-side bus for rptr_level_ctrl: read request, synchronised write pointer in; pointers and flags out.
// underflow_clr exists only when RPTR_UNDERFLOW_STICKY_EN is defined.
interface rptr_level_ctrl_if #(
    parameter int PTR_WIDTH = 3
);
    logic                 r_en;
    logic [PTR_WIDTH:0]   g_wptr_sync;
    logic [PTR_WIDTH:0]   b_rptr;
    logic [PTR_WIDTH:0]   g_rptr;
    logic                 empty;
    logic                 almost_empty;
    logic [PTR_WIDTH:0]   rd_level;
    logic                 rd_ack;
    logic                 underflow;
`ifdef RPTR_UNDERFLOW_STICKY_EN
    logic                 underflow_clr;

    modport master (
        output r_en, g_wptr_sync, underflow_clr,
        input  b_rptr, g_rptr, empty, almost_empty, rd_level, rd_ack, underflow
    );

    modport slave (
        input  r_en, g_wptr_sync, underflow_clr,
        output b_rptr, g_rptr, empty, almost_empty, rd_level, rd_ack, underflow
    );
`else
    modport master (
        output r_en, g_wptr_sync,
        input  b_rptr, g_rptr, empty, almost_empty, rd_level, rd_ack, underflow
    );

    modport slave (
        input  r_en, g_wptr_sync,
        output b_rptr, g_rptr, empty, almost_empty, rd_level, rd_ack, underflow
    );
`endif
endinterface

// File: rtl/rptr_level_ctrl.sv
// Async FIFO read-side pointer, level and flag controller (rclk domain).
// Optional RPTR_UNDERFLOW_STICKY_EN makes underflow sticky until underflow_clr.
module rptr_level_ctrl #(
    parameter int PTR_WIDTH     = 3,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic              rclk,
    input  logic              rrst,
    rptr_level_ctrl_if.slave  bus
);
    localparam int             PW        = PTR_WIDTH + 1;
    localparam logic [PW-1:0]  AE_THRESH = AEMPTY_THRESH[PW-1:0];

    logic [PW-1:0] b_rptr_q, b_rptr_d;
    logic [PW-1:0] g_rptr_q, g_rptr_d;
    logic [PW-1:0] rd_level_q, rd_level_d;
    logic          empty_q, empty_d;
    logic          almost_empty_q, almost_empty_d;
    logic          rd_ack_q, rd_ack_d;
    logic          underflow_q, underflow_d;

    logic          rd_accept;
    logic [PW-1:0] b_next;
    logic [PW-1:0] g_next;
    logic [PW-1:0] b_wsync;
    logic [PW-1:0] level_next;

    // Each decoded bit is the XOR of all Gray bits at or above it.
    always_comb begin
        b_wsync = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            b_wsync[i] = ^(bus.g_wptr_sync >> i);
        end
    end

    always_comb begin
        rd_accept  = bus.r_en & ~empty_q;
        b_next     = b_rptr_q + PW'(rd_accept);
        g_next     = b_next ^ (b_next >> 1);
        level_next = b_wsync - b_next;
    end

    always_comb begin
        b_rptr_d       = b_next;
        g_rptr_d       = g_next;
        empty_d        = (g_next == bus.g_wptr_sync);
        rd_level_d     = level_next;
        almost_empty_d = (level_next <= AE_THRESH);
        rd_ack_d       = rd_accept;
`ifdef RPTR_UNDERFLOW_STICKY_EN
        // Set has priority over clear in the same cycle.
        underflow_d    = (bus.r_en & empty_q) | (underflow_q & ~bus.underflow_clr);
`else
        underflow_d    = bus.r_en & empty_q;
`endif
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            b_rptr_q       <= '0;
            g_rptr_q       <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            rd_level_q     <= '0;
            rd_ack_q       <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            b_rptr_q       <= b_rptr_d;
            g_rptr_q       <= g_rptr_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            rd_level_q     <= rd_level_d;
            rd_ack_q       <= rd_ack_d;
            underflow_q    <= underflow_d;
        end
    end

    assign bus.b_rptr       = b_rptr_q;
    assign bus.g_rptr       = g_rptr_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.rd_level     = rd_level_q;
    assign bus.rd_ack       = rd_ack_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_rptr_level_ctrl.sv
// Self-checking bench for rptr_level_ctrl against a count-based reference model.
module tb_rptr_level_ctrl;
    localparam int PW    = 3;
    localparam int TH    = 1;
    localparam int DEPTH = 8;
    localparam int MOD   = 16;

    logic rclk = 1'b0;
    logic rrst;
    always #5 rclk = ~rclk;

    rptr_level_ctrl_if #(.PTR_WIDTH(PW)) bus ();

    rptr_level_ctrl #(.PTR_WIDTH(PW), .AEMPTY_THRESH(TH)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: read/write counts modulo 16 and derived flags.
    int m_r, m_w, m_lvl;
    bit m_empty, m_ae, m_ack, m_uf;
    bit cur_rst, cur_ren, cur_clr;

    function automatic logic [15:0] obs_vec();
        return {bus.b_rptr, bus.g_rptr, bus.empty, bus.almost_empty,
                bus.rd_level, bus.rd_ack, bus.underflow};
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [3:0] b;
        logic [3:0] g;
        b = 4'(m_r);
        g = b ^ (b >> 1);
        return {b, g, m_empty, m_ae, 4'(m_lvl), m_ack, m_uf};
    endfunction

    task automatic drive(input bit rst, input bit ren, input int w, input bit clr);
        logic [3:0] wb;
        cur_rst = rst;
        cur_ren = ren;
        cur_clr = clr;
        m_w     = w % MOD;
        wb      = 4'(m_w);
        rrst    = rst;
        bus.r_en = ren;
        bus.g_wptr_sync = wb ^ (wb >> 1);
`ifdef RPTR_UNDERFLOW_STICKY_EN
        bus.underflow_clr = clr;
`endif
    endtask

    task automatic step();
        bit acc;
        bit uf_set;
        @(posedge rclk);
        if (cur_rst) begin
            m_r = 0; m_lvl = 0; m_empty = 1; m_ae = 1; m_ack = 0; m_uf = 0;
        end else begin
            acc    = cur_ren && !m_empty;
            uf_set = cur_ren && m_empty;
            m_r    = (m_r + int'(acc)) % MOD;
            m_lvl  = (m_w - m_r + MOD) % MOD;
            m_empty = (m_lvl == 0);
            m_ae    = (m_lvl <= TH);
            m_ack   = acc;
`ifdef RPTR_UNDERFLOW_STICKY_EN
            m_uf    = uf_set || (m_uf && !cur_clr);
`else
            m_uf    = uf_set;
`endif
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0); step();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0); step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL read_while_empty[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (bus.underflow !== 1'b1 || bus.b_rptr !== 4'd0 || bus.rd_ack !== 1'b0) begin
                errors++; $display("FAIL underflow_pulse[%0d]: got uf=%b b=%h ack=%b expected uf=1 b=0 ack=0",
                                   i, bus.underflow, bus.b_rptr, bus.rd_ack);
            end
        end
    endtask

    task automatic test_drain();
        int ack_cnt = 0;
        drive(1, 0, 0, 0); step();
        drive(0, 0, 3, 0); step();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL drain_load: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 3, 0); step();
            ack_cnt += int'(bus.rd_ack);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL drain_read[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.g_rptr !== 4'b0010 || bus.empty !== 1'b1 || bus.rd_level !== 4'd0) begin
            errors++; $display("FAIL drain_final: got g=%b empty=%b lvl=%0d expected g=0010 empty=1 lvl=0",
                               bus.g_rptr, bus.empty, bus.rd_level);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 3, 0); step();
            ack_cnt += int'(bus.rd_ack);
        end
        checks++;
        if (ack_cnt != 3) begin
            errors++; $display("FAIL drain_ack_count: got %0d expected 3", ack_cnt);
        end
    endtask

    task automatic test_full();
        drive(1, 0, 0, 0); step();
        drive(0, 0, 8, 0); step();
        checks++;
        if (obs_vec() !== exp_vec() || bus.rd_level !== 4'd8) begin
            errors++; $display("FAIL full_level: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 8, 0); step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL full_drain[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.b_rptr !== 4'b1000 || bus.g_rptr !== 4'b1100 || bus.underflow !== 1'b1) begin
            errors++; $display("FAIL full_overread: got b=%b g=%b uf=%b expected b=1000 g=1100 uf=1",
                               bus.b_rptr, bus.g_rptr, bus.underflow);
        end
    endtask

    task automatic test_wrap();
        drive(1, 0, 0, 0); step();
        drive(0, 0, 4, 0); step();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 5 + i, 0); step();
            checks++;
            if (obs_vec() !== exp_vec() || bus.empty !== 1'b0) begin
                errors++; $display("FAIL wrap[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_midstream_reset();
        drive(1, 0, 0, 0); step();
        drive(0, 0, 5, 0); step();
        checks++;
        if (bus.rd_level !== 4'd5) begin
            errors++; $display("FAIL mid_setup: got lvl=%0d expected 5", bus.rd_level);
        end
        drive(1, 1, 5, 0); step();
        checks++;
        if (obs_vec() !== exp_vec() || bus.b_rptr !== 4'd0 || bus.rd_level !== 4'd0) begin
            errors++; $display("FAIL mid_reset: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int w;
        bit rst, ren;
        drive(1, 0, 0, 0); step();
        w = 0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            ren = $urandom_range(0, 1) == 1;
            if (rst) w = 0;
            else if (((w - m_r + MOD) % MOD) < DEPTH && $urandom_range(0, 1) == 1) w = (w + 1) % MOD;
            drive(rst, ren, w, 0); step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef RPTR_UNDERFLOW_STICKY_EN
    task automatic test_sticky();
        drive(1, 0, 0, 0); step();
        drive(0, 1, 0, 0); step();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0); step();
            checks++;
            if (obs_vec() !== exp_vec() || bus.underflow !== 1'b1) begin
                errors++; $display("FAIL sticky_hold[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        drive(0, 1, 0, 1); step();
        checks++;
        if (bus.underflow !== 1'b1) begin
            errors++; $display("FAIL sticky_set_wins: got %b expected 1", bus.underflow);
        end
        drive(0, 0, 0, 1); step();
        checks++;
        if (bus.underflow !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL sticky_clear: got uf=%b expected 0", bus.underflow);
        end
    endtask
`endif

    initial begin
        m_r = 0; m_w = 0; m_lvl = 0;
        m_empty = 1; m_ae = 1; m_ack = 0; m_uf = 0;
        drive(1, 0, 0, 0);
        test_reset();
        test_drain();
        test_full();
        test_wrap();
        test_midstream_reset();
        test_random();
`ifdef RPTR_UNDERFLOW_STICKY_EN
        test_sticky();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
